// File: rtl/sc_pkg.sv
// sc_pkg: types shared by the stochastic-computing blocks.
// Rev 1.0
`default_nettype none

package sc_pkg;

   typedef enum logic [1:0] {
      SC_ABS   = 2'b00,
      SC_TANH  = 2'b01,
      SC_EXP   = 2'b10,
      SC_NTANH = 2'b11
   } sc_func_e;

endpackage : sc_pkg

`default_nettype wire

// File: rtl/sc_window_counter.sv
// sc_window_counter: tallies ones in a bitstream over WIN_LEN enabled cycles.
// Rev 1.0
`default_nettype none

module sc_window_counter #(
   parameter int WIN_LEN = 256,
   parameter int CW      = $clog2(WIN_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clear,
   input  logic          bit_in,
   output logic [CW-1:0] ones_count,
   output logic          count_valid
);

   localparam int LW = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
   localparam logic [LW-1:0] C_LAST = LW'(WIN_LEN - 1);

   logic [LW-1:0] cyc_q,   cyc_d;
   logic [CW-1:0] acc_q,   acc_d;
   logic [CW-1:0] ones_q,  ones_d;
   logic          valid_q, valid_d;

   always_comb begin
      cyc_d   = cyc_q;
      acc_d   = acc_q;
      ones_d  = ones_q;
      valid_d = 1'b0;
      if (clear) begin
         cyc_d = '0;
         acc_d = '0;
      end else if (en) begin
         // The closing cycle's own bit is folded in here; the next window starts with no gap.
         if (cyc_q == C_LAST) begin
            ones_d  = acc_q + CW'(bit_in);
            valid_d = 1'b1;
            cyc_d   = '0;
            acc_d   = '0;
         end else begin
            cyc_d = cyc_q + LW'(1);
            acc_d = acc_q + CW'(bit_in);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_q   <= '0;
         acc_q   <= '0;
         ones_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         acc_q   <= acc_d;
         ones_q  <= ones_d;
         valid_q <= valid_d;
      end
   end

   assign ones_count  = ones_q;
   assign count_valid = valid_q;

endmodule : sc_window_counter

`default_nettype wire

// File: rtl/sc_fsm_func.sv
// sc_fsm_func: saturating-counter SC function unit (ABS/TANH/EXP/NTANH) with window readout.
// Rev 1.0
`default_nettype none

module sc_fsm_func
   import sc_pkg::*;
#(
   parameter int N_STATES   = 16,
   parameter int INIT_STATE = 7,
   parameter int EXP_G      = 2,
   parameter int WIN_LEN    = 256,
   parameter int CW         = $clog2(WIN_LEN + 1)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          clear,
   input  sc_func_e      mode,
   input  logic          x,
   output logic          y,
   output logic [CW-1:0] ones_count,
   output logic          count_valid
);

   localparam int SW = $clog2(N_STATES);
   localparam logic [SW-1:0] S_MAX  = SW'(N_STATES - 1);
   localparam logic [SW-1:0] S_INIT = SW'(INIT_STATE);
   localparam logic [SW-1:0] S_HALF = SW'(N_STATES / 2);
   localparam logic [SW-1:0] S_EXP  = SW'(N_STATES - EXP_G);

   logic [SW-1:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = S_INIT;
      end else if (en) begin
         if (x) begin
            if (state_q != S_MAX) state_d = state_q + SW'(1);
         end else begin
            if (state_q != '0) state_d = state_q - SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_INIT;
      else          state_q <= state_d;
   end

   // Pure Moore decode: y depends only on the state and the selected function.
   always_comb begin
      y = 1'b0;
      case (mode)
         SC_ABS:   y = state_q[SW-1] ? state_q[0] : ~state_q[0];
         SC_TANH:  y = (state_q >= S_HALF);
         SC_EXP:   y = (state_q <  S_EXP);
         SC_NTANH: y = (state_q <  S_HALF);
         default:  y = 1'b0;
      endcase
   end

   sc_window_counter #(
      .WIN_LEN (WIN_LEN),
      .CW      (CW)
   ) u_window (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .clear       (clear),
      .bit_in      (y),
      .ones_count  (ones_count),
      .count_valid (count_valid)
   );

endmodule : sc_fsm_func

`default_nettype wire

// File: tb/tb_sc_fsm_func.sv
// tb_sc_fsm_func: randomized self-checking bench against an arithmetic reference model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_sc_fsm_func;
   import sc_pkg::*;

   localparam int N_STATES   = 16;
   localparam int INIT_STATE = 7;
   localparam int EXP_G      = 2;
   localparam int WIN_LEN    = 256;
   localparam int CW         = $clog2(WIN_LEN + 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          en;
   logic          clear;
   sc_func_e      mode;
   logic          x;
   logic          y;
   logic [CW-1:0] ones_count;
   logic          count_valid;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_s, m_cyc, m_acc, m_ones;
   bit m_valid;

   always #5 clk = ~clk;

   sc_fsm_func #(
      .N_STATES   (N_STATES),
      .INIT_STATE (INIT_STATE),
      .EXP_G      (EXP_G),
      .WIN_LEN    (WIN_LEN)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .clear       (clear),
      .mode        (mode),
      .x           (x),
      .y           (y),
      .ones_count  (ones_count),
      .count_valid (count_valid)
   );

   function automatic bit ref_y(sc_func_e m, int s);
      case (m)
         SC_ABS:  return (s < N_STATES / 2) ? (s % 2 == 0) : (s % 2 == 1);
         SC_TANH: return s >= N_STATES / 2;
         SC_EXP:  return s < N_STATES - EXP_G;
         default: return s < N_STATES / 2;
      endcase
   endfunction

   task automatic model_reset();
      m_s = INIT_STATE; m_cyc = 0; m_acc = 0; m_ones = 0; m_valid = 0;
   endtask

   task automatic do_reset();
      en = 0; clear = 0; x = 0; mode = SC_ABS;
      reset_n = 0;
      model_reset();
      #12;
      reset_n = 1;
      @(posedge clk); #1;
   endtask

   // One clock: apply inputs, advance model, compare all outputs.
   task automatic step(input bit e, input bit xi, input bit cl, input sc_func_e md, input string tag);
      bit yo;
      en = e; x = xi; clear = cl; mode = md;
      @(posedge clk);
      yo = ref_y(md, m_s);
      m_valid = 0;
      if (cl) begin
         m_s = INIT_STATE; m_cyc = 0; m_acc = 0;
      end else if (e) begin
         m_cyc++;
         m_acc += yo;
         if (m_cyc == WIN_LEN) begin
            m_ones = m_acc; m_valid = 1; m_cyc = 0; m_acc = 0;
         end
         m_s = xi ? ((m_s + 1 > N_STATES - 1) ? N_STATES - 1 : m_s + 1)
                  : ((m_s - 1 < 0) ? 0 : m_s - 1);
      end
      #1;
      n_checks += 3;
      if (y !== ref_y(md, m_s)) begin
         n_fail++; $display("FAIL %s y: got %b exp %b (s=%0d)", tag, y, ref_y(md, m_s), m_s);
      end
      if (count_valid !== m_valid) begin
         n_fail++; $display("FAIL %s count_valid: got %b exp %b", tag, count_valid, m_valid);
      end
      if (ones_count !== CW'(m_ones)) begin
         n_fail++; $display("FAIL %s ones_count: got %0d exp %0d", tag, ones_count, m_ones);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_checks += 3;
      if (y !== 1'b0)          begin n_fail++; $display("FAIL reset_y: got %b exp 0", y); end
      if (ones_count !== '0)   begin n_fail++; $display("FAIL reset_ones: got %0d exp 0", ones_count); end
      if (count_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", count_valid); end
   endtask

   task automatic test_abs_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 1, 0, SC_ABS, "abs_up");
      n_checks++;
      if (y !== 1'b1) begin n_fail++; $display("FAIL abs_top_y: got %b exp 1", y); end
      for (int i = 0; i < 20; i++) step(1, 0, 0, SC_ABS, "abs_down");
      n_checks++;
      if (y !== 1'b1) begin n_fail++; $display("FAIL abs_bottom_y: got %b exp 1", y); end
      step(1, 0, 1, SC_ABS, "abs_clear");
      for (int i = 0; i < 12; i++) begin
         step(1, (i % 2 == 0), 0, SC_ABS, "abs_alt");
         n_checks++;
         if (y !== 1'b0) begin n_fail++; $display("FAIL abs_alt_y: got %b exp 0", y); end
      end
   endtask

   task automatic test_tanh_window();
      int pulses = 0;
      do_reset();
      mode = SC_TANH; #1;
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL tanh_cycle0_y: got %b exp 0", y); end
      for (int i = 0; i < WIN_LEN; i++) begin
         step(1, 1, 0, SC_TANH, "tanh_win");
         pulses += count_valid;
      end
      n_checks += 2;
      if (pulses != 1)           begin n_fail++; $display("FAIL tanh_pulses: got %0d exp 1", pulses); end
      if (ones_count !== CW'(255)) begin n_fail++; $display("FAIL tanh_ones: got %0d exp 255", ones_count); end
      step(1, 1, 0, SC_TANH, "tanh_after");
   endtask

   task automatic test_exp_ntanh();
      do_reset();
      for (int i = 0; i < 6; i++) step(1, 1, 0, SC_EXP, "exp_up");
      n_checks++;
      if (y !== 1'b1) begin n_fail++; $display("FAIL exp_s13: got %b exp 1", y); end
      step(1, 1, 0, SC_EXP, "exp_14");
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL exp_s14: got %b exp 0", y); end
      step(1, 1, 0, SC_EXP, "exp_15");
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL exp_s15: got %b exp 0", y); end
      step(1, 0, 1, SC_EXP, "exp_clear");
      mode = SC_NTANH; #1;
      n_checks++;
      if (y !== 1'b1) begin n_fail++; $display("FAIL ntanh_s7: got %b exp 1", y); end
      step(1, 1, 0, SC_NTANH, "ntanh_8");
      n_checks++;
      if (y !== 1'b0) begin n_fail++; $display("FAIL ntanh_s8: got %b exp 0", y); end
   endtask

   task automatic test_en_gaps();
      int first_valid = -1;
      do_reset();
      for (int i = 1; i <= 2 * WIN_LEN + 8; i++) begin
         step((i % 2 == 1), 1'($urandom), 0, SC_TANH, "en_gap");
         if (count_valid && first_valid < 0) first_valid = i;
      end
      n_checks++;
      if (first_valid != 2 * WIN_LEN - 1) begin
         n_fail++; $display("FAIL en_gap_valid_clock: got %0d exp %0d", first_valid, 2 * WIN_LEN - 1);
      end
   endtask

   task automatic test_clear_and_reset();
      do_reset();
      for (int i = 0; i < 300; i++) step(1, 1'($urandom), 0, sc_func_e'($urandom_range(0, 3)), "pre_clear");
      step(1, 1, 1, SC_ABS, "clear_en");
      n_checks++;
      if (count_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b exp 0", count_valid); end
      for (int i = 0; i < WIN_LEN + 40; i++) step(1, 1'($urandom), 0, SC_TANH, "post_clear");
      #2 reset_n = 0;
      model_reset();
      #1;
      n_checks += 3;
      if (y !== ref_y(SC_TANH, INIT_STATE)) begin n_fail++; $display("FAIL async_y: got %b exp %b", y, ref_y(SC_TANH, INIT_STATE)); end
      if (ones_count !== '0)    begin n_fail++; $display("FAIL async_ones: got %0d exp 0", ones_count); end
      if (count_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b exp 0", count_valid); end
      #2 reset_n = 1;
      for (int i = 0; i < WIN_LEN + 10; i++) step(1, 1'($urandom), 0, SC_EXP, "post_reset");
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 99) == 0,
              sc_func_e'($urandom_range(0, 3)), "random");
   endtask

   initial begin
      reset_n = 0; en = 0; clear = 0; x = 0; mode = SC_ABS;
      test_reset();
      test_abs_saturation();
      test_tanh_window();
      test_exp_ntanh();
      test_en_gaps();
      test_clear_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_sc_fsm_func

`default_nettype wire
